// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing constants and helpers shared by the scan generator.
package vga_timing_pkg;

  localparam int DEF_CLK_DIV    = 2;
  localparam int DEF_H_VISIBLE  = 640;
  localparam int DEF_H_FRONT    = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BACK     = 48;
  localparam int DEF_V_VISIBLE  = 480;
  localparam int DEF_V_FRONT    = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BACK     = 33;
  localparam int DEF_PIPE_DELAY = 2;

  // Sync/blank bundle carried through the latency-matching delay line.
  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic blk;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, blk: 1'b1};

  function automatic int h_total(input int visible, input int front, input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  function automatic int v_total(input int visible, input int front, input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/sync_delay.sv
// Clock-enabled shift register with a reset value; DEPTH=0 degenerates to a wire.
module sync_delay #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused;
      assign unused = ^{clk, rst, ce};
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stages [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stages[i] <= RESET_VAL;
        end else if (ce) begin
          stages[0] <= d;
          for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
      end

      assign q = stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster scan generator: pixel strobe, half-resolution coordinates for the
// background renderer, latency-matched sync/blank and a frame-end pulse.
module vga_scan_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int PIPE_DELAY = DEF_PIPE_DELAY
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_ce,
  output logic [8:0] pixel_x,
  output logic [7:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       frame_end
);

  localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [8:0] X_BLANK  = 9'(H_VISIBLE / 2);
  localparam logic [7:0] Y_BLANK  = 8'(V_VISIBLE / 2);

  logic [DIV_W-1:0] div;
  logic [9:0]       h;
  logic [9:0]       v;
  logic             line_end;
  sync_t            raw;
  sync_t            dly;

  assign pix_ce   = (div == DIV_LAST);
  assign line_end = (h == H_LAST);

  // With CLK_DIV=1 the strobe is always high, so div simply stays at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else if (pix_ce) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (pix_ce) begin
      h <= line_end ? '0 : h + 10'd1;
      if (line_end) v <= (v == V_LAST) ? '0 : v + 10'd1;
    end
  end

  assign raw.hs_n = !((h >= HS_START) && (h < HS_END));
  assign raw.vs_n = !((v >= VS_START) && (v < VS_END));
  assign raw.blk  = (h >= H_VIS) || (v >= V_VIS);

  assign pixel_x   = (h < H_VIS) ? h[9:1] : X_BLANK;
  assign pixel_y   = (v < V_VIS) ? v[8:1] : Y_BLANK;
  assign frame_end = pix_ce && line_end && (v == V_LAST);

  // Sync/blank are delayed to line up with the renderer's memory latency; coordinates are not.
  sync_delay #(
    .WIDTH    (3),
    .DEPTH    (PIPE_DELAY),
    .RESET_VAL(SYNC_IDLE)
  ) u_sync_delay (
    .clk(clk),
    .rst(rst),
    .ce (pix_ce),
    .d  (raw),
    .q  (dly)
  );

  assign hsync = dly.hs_n;
  assign vsync = dly.vs_n;
  assign blank = dly.blk;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench for vga_scan_gen on a shrunken raster, three divider/delay configurations.
module tb_vga_scan_gen;

  localparam int HV = 16, HF = 2, HS = 3, HB = 3;
  localparam int VV = 8,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int PD_A = 2, PD_B = 0, PD_C = 3;

  typedef struct packed {
    logic hs;
    logic vs;
    logic bk;
  } trip_t;

  localparam trip_t IDLE = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       ce_a, ce_b, ce_c;
  logic [8:0] px_a, px_b, px_c;
  logic [7:0] py_a, py_b, py_c;
  logic       hs_a, hs_b, hs_c, vs_a, vs_b, vs_c;
  logic       bk_a, bk_b, bk_c, fe_a, fe_b, fe_c;

  vga_scan_gen #(.CLK_DIV(2), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                 .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .PIPE_DELAY(PD_A))
    dut_a (.clk(clk), .rst(rst), .pix_ce(ce_a), .pixel_x(px_a), .pixel_y(py_a),
           .hsync(hs_a), .vsync(vs_a), .blank(bk_a), .frame_end(fe_a));

  vga_scan_gen #(.CLK_DIV(2), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                 .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .PIPE_DELAY(PD_B))
    dut_b (.clk(clk), .rst(rst), .pix_ce(ce_b), .pixel_x(px_b), .pixel_y(py_b),
           .hsync(hs_b), .vsync(vs_b), .blank(bk_b), .frame_end(fe_b));

  vga_scan_gen #(.CLK_DIV(1), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                 .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .PIPE_DELAY(PD_C))
    dut_c (.clk(clk), .rst(rst), .pix_ce(ce_c), .pixel_x(px_c), .pixel_y(py_c),
           .hsync(hs_c), .vsync(vs_c), .blank(bk_c), .frame_end(fe_c));

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    fe_cnt_a = 0, fe_cnt_b = 0, fe_cnt_c = 0;
  trip_t qa[$], qb[$], qc[$];
  trip_t ea, eb, ec;

  // Ideal undelayed sync/blank for the p-th pixel period since reset.
  function automatic trip_t ideal(input int p);
    int    h;
    int    v;
    trip_t t;
    h = p % HT;
    v = (p / HT) % VT;
    t.hs = !((h >= HV + HF) && (h < HV + HF + HS));
    t.vs = !((v >= VV + VF) && (v < VV + VF + VS));
    t.bk = (h >= HV) || (v >= VV);
    return t;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_inst(input string name, input int d, input trip_t es,
                            input logic ce, input logic [8:0] px, input logic [7:0] py,
                            input logic hs, input logic vs, input logic bk, input logic fe);
    int   p;
    int   h;
    int   v;
    logic exp_ce;
    p = cyc / d;
    h = p % HT;
    v = (p / HT) % VT;
    exp_ce = ((cyc % d) == d - 1);
    check_output({name, ".pix_ce"},    ce, exp_ce);
    check_output({name, ".pixel_x"},   px, (h < HV) ? h / 2 : HV / 2);
    check_output({name, ".pixel_y"},   py, (v < VV) ? v / 2 : VV / 2);
    check_output({name, ".hsync"},     hs, es.hs);
    check_output({name, ".vsync"},     vs, es.vs);
    check_output({name, ".blank"},     bk, es.bk);
    check_output({name, ".frame_end"}, fe, exp_ce && (h == HT - 1) && (v == VT - 1));
  endtask

  // On each new pixel period the ideal value enters the queue and the one PD periods old leaves.
  task automatic check_all();
    if (cyc % 2 == 0) begin
      qa.push_back(ideal(cyc / 2)); ea = qa.pop_front();
      qb.push_back(ideal(cyc / 2)); eb = qb.pop_front();
    end
    qc.push_back(ideal(cyc)); ec = qc.pop_front();
    check_inst("a", 2, ea, ce_a, px_a, py_a, hs_a, vs_a, bk_a, fe_a);
    check_inst("b", 2, eb, ce_b, px_b, py_b, hs_b, vs_b, bk_b, fe_b);
    check_inst("c", 1, ec, ce_c, px_c, py_c, hs_c, vs_c, bk_c, fe_c);
    if (fe_a === 1'b1) fe_cnt_a++;
    if (fe_b === 1'b1) fe_cnt_b++;
    if (fe_c === 1'b1) fe_cnt_c++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    qa.delete(); qb.delete(); qc.delete();
    repeat (PD_A) qa.push_back(IDLE);
    repeat (PD_B) qb.push_back(IDLE);
    repeat (PD_C) qc.push_back(IDLE);
    fe_cnt_a = 0; fe_cnt_b = 0; fe_cnt_c = 0;
    check_all();
    rst = 1'b0;
  endtask

  task automatic apply_stimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      check_all();
    end
  endtask

  initial begin
    int   guard;
    logic found;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    $display("[TB] reset release and two full frames");
    apply_reset();
    apply_stimulus(2 * 2 * HT * VT);
    check_output("fe_count_a", fe_cnt_a, 2);
    check_output("fe_count_b", fe_cnt_b, 2);
    check_output("fe_count_c", fe_cnt_c, 4);

    $display("[TB] seeking mid-frame point h=10 v=5 for reset");
    guard = 0;
    found = 1'b0;
    while (!found && guard < 2000) begin
      apply_stimulus(1);
      guard++;
      found = (cyc % 2 == 0) && ((cyc / 2) % HT == 10) && (((cyc / 2) / HT) % VT == 5);
    end
    check_output("seek_mid_frame", found, 1'b1);

    apply_reset();
    apply_stimulus(700);
    check_output("fe_count_a_after_rst", fe_cnt_a, 1);
    check_output("fe_count_c_after_rst", fe_cnt_c, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
